// File: rtl/flash_arb_pkg.sv
// Shared types and default timing for the flash bus arbiter.
package flash_arb_pkg;

  localparam int CNT_W        = 8;
  localparam int DEF_T_SETUP  = 1;
  localparam int DEF_T_STROBE = 4;
  localparam int DEF_T_HOLD   = 1;
  localparam int DEF_TURN_CYC = 2;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    TURN_TO_PFL,
    PFL,
    TURN_TO_HOST
  } state_t;

endpackage

// File: rtl/flash_arb_timer.sv
// Loadable down-counter; holds at zero and flags terminal count.
module flash_arb_timer
  import flash_arb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/flash_bus_arbiter.sv
// Shares the CFI flash bus between the PFL and a host word-access port.
//
// state        | meaning
// IDLE         | host owns bus, strobes idle, arbitrating
// SETUP        | nCE/address (and write data) valid before strobe
// STROBE       | nOE or nWE low
// HOLD         | strobe released, nCE/address still held
// TURN_TO_PFL  | bus released, waiting before granting PFL
// PFL          | PFL granted, follows pfl_req
// TURN_TO_HOST | grant dropped, waiting before retaking the bus
module flash_bus_arbiter
  import flash_arb_pkg::*;
#(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int T_SETUP  = DEF_T_SETUP,
  parameter int T_STROBE = DEF_T_STROBE,
  parameter int T_HOLD   = DEF_T_HOLD,
  parameter int TURN_CYC = DEF_TURN_CYC
)(
  input  logic              pfl_clk,
  input  logic              pfl_reset,
  input  logic              pfl_req,
  output logic              pfl_grant,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              host_busy,
  output logic              host_owns_bus,
  output logic [ADDR_W-1:0] flash_addr,
  output logic              flash_nce,
  output logic              flash_noe,
  output logic              flash_nwe,
  output logic [DATA_W-1:0] flash_dq_out,
  output logic              flash_dq_oe,
  input  logic [DATA_W-1:0] flash_dq_in
);

  state_t state, state_next;

  logic             cnt_zero;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              accept;
  logic              in_acc;
  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;

  logic              grant_d, ack_d, busy_d, owns_d;
  logic              nce_d, noe_d, nwe_d, dq_oe_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] dq_out_d, rdata_d;

  flash_arb_timer u_timer (
    .clk      (pfl_clk),
    .rst      (pfl_reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_ff @(posedge pfl_clk or posedge pfl_reset) begin
    if (pfl_reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Accept is held off during the ack cycle so a held host_req is only
  // taken as a new access in the cycle after the ack.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (pfl_req)
          state_next = TURN_TO_PFL;
        else if (host_req && !host_ack)
          state_next = SETUP;
      end
      SETUP:        if (cnt_zero) state_next = STROBE;
      STROBE:       if (cnt_zero) state_next = HOLD;
      HOLD:         if (cnt_zero) state_next = IDLE;
      TURN_TO_PFL:  if (cnt_zero) state_next = PFL;
      PFL:          if (!pfl_req) state_next = TURN_TO_HOST;
      TURN_TO_HOST: if (cnt_zero) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_comb begin
    cnt_load = (state_next != state);
    case (state_next)
      SETUP:        cnt_val = CNT_W'(T_SETUP - 1);
      STROBE:       cnt_val = CNT_W'(T_STROBE - 1);
      HOLD:         cnt_val = CNT_W'(T_HOLD - 1);
      TURN_TO_PFL,
      TURN_TO_HOST: cnt_val = CNT_W'(TURN_CYC - 1);
      default:      cnt_val = '0;
    endcase
  end

  always_ff @(posedge pfl_clk or posedge pfl_reset) begin
    if (pfl_reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= host_we;
      addr_q  <= host_addr;
      wdata_q <= host_wdata;
    end
  end

  // Outputs are decoded from the next state so they change on the same
  // edge as the state they belong to.
  always_comb begin
    accept    = (state == IDLE) && (state_next == SETUP);
    acc_we    = accept ? host_we    : we_q;
    acc_addr  = accept ? host_addr  : addr_q;
    acc_wdata = accept ? host_wdata : wdata_q;
    in_acc    = (state_next == SETUP) || (state_next == STROBE) || (state_next == HOLD);

    nce_d     = !in_acc;
    noe_d     = !((state_next == STROBE) && !acc_we);
    nwe_d     = !((state_next == STROBE) && acc_we);
    dq_oe_d   = in_acc && acc_we;
    addr_d    = in_acc ? acc_addr : '0;
    dq_out_d  = in_acc ? acc_wdata : '0;
    ack_d     = (state == HOLD) && (state_next == IDLE);
    busy_d    = in_acc || ack_d;
    grant_d   = (state_next == PFL);
    owns_d    = (state_next == IDLE) || in_acc;
    rdata_d   = host_rdata;
    if ((state == STROBE) && (state_next == HOLD) && !we_q)
      rdata_d = flash_dq_in;
  end

  always_ff @(posedge pfl_clk or posedge pfl_reset) begin
    if (pfl_reset) begin
      pfl_grant     <= 1'b0;
      host_ack      <= 1'b0;
      host_busy     <= 1'b0;
      host_owns_bus <= 1'b1;
      flash_nce     <= 1'b1;
      flash_noe     <= 1'b1;
      flash_nwe     <= 1'b1;
      flash_dq_oe   <= 1'b0;
      flash_addr    <= '0;
      flash_dq_out  <= '0;
      host_rdata    <= '0;
    end else begin
      pfl_grant     <= grant_d;
      host_ack      <= ack_d;
      host_busy     <= busy_d;
      host_owns_bus <= owns_d;
      flash_nce     <= nce_d;
      flash_noe     <= noe_d;
      flash_nwe     <= nwe_d;
      flash_dq_oe   <= dq_oe_d;
      flash_addr    <= addr_d;
      flash_dq_out  <= dq_out_d;
      host_rdata    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_flash_bus_arbiter.sv
// Directed bench for flash_bus_arbiter with a small flash pin model.
module tb_flash_bus_arbiter;

  localparam int ADDR_W = 25;
  localparam int DATA_W = 16;

  logic              pfl_clk   = 1'b0;
  logic              pfl_reset = 1'b1;
  logic              pfl_req   = 1'b0;
  logic              pfl_grant;
  logic              host_req  = 1'b0;
  logic              host_we   = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic [DATA_W-1:0] host_rdata;
  logic              host_ack;
  logic              host_busy;
  logic              host_owns_bus;
  logic [ADDR_W-1:0] flash_addr;
  logic              flash_nce;
  logic              flash_noe;
  logic              flash_nwe;
  logic [DATA_W-1:0] flash_dq_out;
  logic              flash_dq_oe;
  logic [DATA_W-1:0] flash_dq_in;

  logic [DATA_W-1:0] rd_word = '0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  int                wr_cnt  = 0;

  int n_chk  = 0;
  int n_pass = 0;
  int inv_err = 0;
  logic prev_grant = 1'b0;
  logic prev_owns  = 1'b1;

  logic [31:0] tr_nce, tr_noe, tr_nwe, tr_oe, tr_ack, tr_busy, tr_grant, tr_own;
  logic [DATA_W-1:0] tr_rdata;

  flash_bus_arbiter dut (
    .pfl_clk       (pfl_clk),
    .pfl_reset     (pfl_reset),
    .pfl_req       (pfl_req),
    .pfl_grant     (pfl_grant),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_rdata    (host_rdata),
    .host_ack      (host_ack),
    .host_busy     (host_busy),
    .host_owns_bus (host_owns_bus),
    .flash_addr    (flash_addr),
    .flash_nce     (flash_nce),
    .flash_noe     (flash_noe),
    .flash_nwe     (flash_nwe),
    .flash_dq_out  (flash_dq_out),
    .flash_dq_oe   (flash_dq_oe),
    .flash_dq_in   (flash_dq_in)
  );

  always #5 pfl_clk = ~pfl_clk;

  // Flash device: drives data while selected and output-enabled,
  // latches written data on the rising edge of nWE.
  assign flash_dq_in = (!flash_nce && !flash_noe) ? rd_word : '0;

  always @(posedge flash_nwe) begin
    if (!flash_nce && flash_dq_oe) begin
      wr_addr = flash_addr;
      wr_data = flash_dq_out;
      wr_cnt  = wr_cnt + 1;
    end
  end

  // Ownership invariant: never both high, never both toggling together.
  always @(negedge pfl_clk) begin
    if (pfl_grant && host_owns_bus)
      inv_err = inv_err + 1;
    if ((pfl_grant != prev_grant) && (host_owns_bus != prev_owns))
      inv_err = inv_err + 1;
    prev_grant = pfl_grant;
    prev_owns  = host_owns_bus;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (act === exp)
      n_pass = n_pass + 1;
    else
      $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  // Records one bit per edge k (edge 0 is the first edge after the call).
  task automatic trace(input int n, input int acks_to_drop, input int pfl_set_k, input int pfl_clr_k);
    int acks;
    acks = 0;
    tr_nce = '0; tr_noe = '0; tr_nwe = '0; tr_oe = '0;
    tr_ack = '0; tr_busy = '0; tr_grant = '0; tr_own = '0;
    tr_rdata = '0;
    for (int k = 0; k < n; k++) begin
      @(posedge pfl_clk);
      #1;
      tr_nce[k[4:0]]   = !flash_nce;
      tr_noe[k[4:0]]   = !flash_noe;
      tr_nwe[k[4:0]]   = !flash_nwe;
      tr_oe[k[4:0]]    = flash_dq_oe;
      tr_ack[k[4:0]]   = host_ack;
      tr_busy[k[4:0]]  = host_busy;
      tr_grant[k[4:0]] = pfl_grant;
      tr_own[k[4:0]]   = host_owns_bus;
      if (host_ack) begin
        tr_rdata = host_rdata;
        acks = acks + 1;
        if (acks == acks_to_drop)
          host_req = 1'b0;
      end
      if (k == pfl_set_k) pfl_req = 1'b1;
      if (k == pfl_clr_k) pfl_req = 1'b0;
    end
  endtask

  task automatic host_start(input logic we, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    host_we    = we;
    host_addr  = addr;
    host_wdata = wdata;
    host_req   = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge pfl_clk);
    #1 pfl_reset = 1'b0;
    #1;
    chk("rst_grant", 32'(pfl_grant), 32'h0);
    chk("rst_ack",   32'(host_ack), 32'h0);
    chk("rst_busy",  32'(host_busy), 32'h0);
    chk("rst_owns",  32'(host_owns_bus), 32'h1);
    chk("rst_strobes", {29'h0, flash_nce, flash_noe, flash_nwe}, 32'h7);
    chk("rst_dq_oe", 32'(flash_dq_oe), 32'h0);
    chk("rst_addr",  32'(flash_addr), 32'h0);
    chk("rst_dq_out", 32'(flash_dq_out), 32'h0);
    chk("rst_rdata", 32'(host_rdata), 32'h0);

    // 1: single read with default timing
    rd_word = 16'hBEEF;
    host_start(1'b0, 25'h0123456, 16'h0000);
    trace(8, 1, -1, -1);
    chk("rd_nce",   tr_nce,  32'h3F);
    chk("rd_noe",   tr_noe,  32'h1E);
    chk("rd_nwe",   tr_nwe,  32'h00);
    chk("rd_ack",   tr_ack,  32'h40);
    chk("rd_busy",  tr_busy, 32'h7F);
    chk("rd_data",  32'(host_rdata), 32'hBEEF);

    // 2: single write to the top word
    host_start(1'b1, 25'h1FFFFFF, 16'hA55A);
    trace(8, 1, -1, -1);
    chk("wr_nwe",   tr_nwe, 32'h1E);
    chk("wr_noe",   tr_noe, 32'h00);
    chk("wr_oe",    tr_oe,  32'h3F);
    chk("wr_ack",   tr_ack, 32'h40);
    chk("wr_addr",  32'(wr_addr), 32'h1FFFFFF);
    chk("wr_data",  32'(wr_data), 32'hA55A);
    chk("wr_cnt",   32'(wr_cnt), 32'h1);
    chk("wr_rdata_kept", 32'(host_rdata), 32'hBEEF);

    // 3: PFL and host request together; PFL first, host access afterwards
    rd_word = 16'h1234;
    pfl_req = 1'b1;
    host_start(1'b0, 25'h0000ABC, 16'h0000);
    trace(4, 1, -1, 3);
    chk("sim_owns",  tr_own,   32'h0);
    chk("sim_grant", tr_grant, 32'hC);
    chk("sim_nce",   tr_nce,   32'h0);
    trace(11, 1, -1, -1);
    chk("sim_grant_rel", tr_grant, 32'h0);
    chk("sim_owns_back", tr_own,   32'h7FC);
    chk("sim_host_nce",  tr_nce,   32'h1F8);
    chk("sim_host_ack",  tr_ack,   32'h200);
    chk("sim_host_data", 32'(tr_rdata), 32'h1234);

    // 4: PFL request arriving mid-STROBE waits for the read to finish
    rd_word = 16'hC0DE;
    host_start(1'b0, 25'h0000100, 16'h0000);
    trace(16, 1, 2, 11);
    chk("mid_noe",   tr_noe,   32'h1E);
    chk("mid_ack",   tr_ack,   32'h40);
    chk("mid_data",  32'(tr_rdata), 32'hC0DE);
    chk("mid_owns",  tr_own,   32'hC07F);
    chk("mid_grant", tr_grant, 32'hE00);

    // 5: reset during the strobe of a write aborts at once
    host_start(1'b1, 25'h0000200, 16'h5A5A);
    repeat (3) @(posedge pfl_clk);
    #2;
    chk("rstw_pre_nwe", 32'(flash_nwe), 32'h0);
    pfl_reset = 1'b1;
    host_req  = 1'b0;
    #1;
    chk("rstw_nwe",   32'(flash_nwe), 32'h1);
    chk("rstw_nce",   32'(flash_nce), 32'h1);
    chk("rstw_oe",    32'(flash_dq_oe), 32'h0);
    chk("rstw_ack",   32'(host_ack), 32'h0);
    chk("rstw_busy",  32'(host_busy), 32'h0);
    @(posedge pfl_clk);
    #1 pfl_reset = 1'b0;
    trace(6, 1, -1, -1);
    chk("rstw_owns",     tr_own, 32'h3F);
    chk("rstw_no_ack",   tr_ack, 32'h0);
    chk("rstw_idle_nce", tr_nce, 32'h0);

    // 6: host_req held for two back-to-back reads
    rd_word = 16'h7E57;
    host_start(1'b0, 25'h0000300, 16'h0000);
    trace(16, 2, -1, -1);
    chk("b2b_ack",  tr_ack,  32'h4040);
    chk("b2b_nce",  tr_nce,  32'h3F3F);
    chk("b2b_busy", tr_busy, 32'h7F7F);
    chk("b2b_data", 32'(tr_rdata), 32'h7E57);

    chk("grant_owns_invariant", 32'(inv_err), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
